chunked_addsub: RTL and testbench

Multi-cycle, parametrised add/subtract unit that processes operands LSB-first in CHUNK_WIDTH-bit slices, one slice per clock, with a valid/ready handshake on both sides. Successor to the single-cycle ripple adder in the Turing-machine datapath (head-position and counter arithmetic). It adds subtraction, a honoured carry-in, signed-overflow and zero flags, and a width/latency trade-off through CHUNK_WIDTH.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/chunk_adder.sv | 29 ++
 rtl/chunked_addsub.sv | 140 ++++++++++++++
 tb/tb_chunked_addsub.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked add/subtract unit: opcodes, FSM states
// and the chunk-count helper.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned num_chunks(int unsigned data_width,
                                               int unsigned chunk_width);
        return (data_width + chunk_width - 1) / chunk_width;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple adder for one chunk; also exposes the carry into its
// MSB so the top level can derive signed overflow on the final chunk.
module chunk_adder #(
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   cmsb
);

    logic [CHUNK_WIDTH:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK_WIDTH];
    assign cmsb = c[CHUNK_WIDTH-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: operands are processed LSB-first, one
// CHUNK_WIDTH-bit slice per clock, with valid/ready handshakes on both sides.
module chunked_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  op,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero
);

    localparam int unsigned NUM_CHUNKS = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
    localparam int unsigned PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int unsigned LAST_W     = DATA_WIDTH - (NUM_CHUNKS - 1) * CHUNK_WIDTH;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_CHUNKS - 1);

    state_t               state_q, state_d;
    logic [PAD_WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d;
    logic [CNT_W-1:0]     k_q, k_d;
    logic                 carry_q, carry_d;
    logic                 cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [CHUNK_WIDTH-1:0] sum;
    logic                   add_cout, add_cmsb;
    logic                   fin_cout, fin_cmsb;
    logic [DATA_WIDTH-1:0]  b_in;
    int unsigned            base;

    chunk_adder #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk_adder (
        .a    (a_q[CHUNK_WIDTH-1:0]),
        .b    (b_q[CHUNK_WIDTH-1:0]),
        .cin  (carry_q),
        .sum  (sum),
        .cout (add_cout),
        .cmsb (add_cmsb)
    );

    // Operands are zero-padded, so in a partial last chunk the carry out of the
    // data MSB lands in the first padding sum bit.
    if (LAST_W < CHUNK_WIDTH) begin : g_partial
        logic unused_adder_flags;
        assign fin_cout = sum[LAST_W];
        assign fin_cmsb = sum[LAST_W-1] ^ a_q[LAST_W-1] ^ b_q[LAST_W-1];
        assign unused_adder_flags = add_cmsb;
    end else begin : g_full
        assign fin_cout = add_cout;
        assign fin_cmsb = add_cmsb;
    end

    assign b_in = (op == OP_SUB) ? ~b : b;
    assign base = k_q * CHUNK_WIDTH;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = PAD_WIDTH'(a);
                    b_d     = PAD_WIDTH'(b_in);
                    carry_d = (op == OP_SUB) ? ~cin : cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                q_d[base +: CHUNK_WIDTH] = sum;
                carry_d = add_cout;
                a_d     = a_q >> CHUNK_WIDTH;
                b_d     = b_q >> CHUNK_WIDTH;
                k_d     = k_q + CNT_W'(1);
                if (k_q == LAST_K) begin
                    cout_d  = fin_cout;
                    ovf_d   = fin_cout ^ fin_cmsb;
                    zero_d  = (q_d[DATA_WIDTH-1:0] == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q[DATA_WIDTH-1:0];
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: four instances (CHUNK_WIDTH 4, 1, 3, 14) checked
// against directed vectors, handshake sequences and an arithmetic model.
module tb_chunked_addsub;

    localparam int DW = 14;
    localparam int NI = 4;

    function automatic int unsigned cw_of(int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 3;
            default: return 14;
        endcase
    endfunction

    function automatic int nch_of(int g);
        return (DW + int'(cw_of(g)) - 1) / int'(cw_of(g));
    endfunction

    typedef struct packed {
        logic [DW-1:0] q;
        logic          cout;
        logic          ovf;
        logic          zero;
    } res_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          op;
        logic          cin;
        res_t          exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [NI-1:0] in_valid, out_ready;
    logic [DW-1:0] a, b;
    logic          op, cin;
    logic          in_ready [NI];
    logic          out_valid[NI];
    logic [DW-1:0] q        [NI];
    logic          cout     [NI];
    logic          ovf      [NI];
    logic          zero     [NI];

    int total = 0;
    int bad   = 0;
    int lat[NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        chunked_addsub #(
            .DATA_WIDTH  (DW),
            .CHUNK_WIDTH (cw_of(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .op        (op),
            .cin       (cin),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .q         (q[g]),
            .cout      (cout[g]),
            .ovf       (ovf[g]),
            .zero      (zero[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(logic [DW-1:0] va, logic [DW-1:0] vb, logic vop, logic vcin);
        int ua, ub, sa, sb, ru, rs;
        res_t r;
        ua = int'(va);
        ub = int'(vb);
        sa = va[DW-1] ? ua - (1 << DW) : ua;
        sb = vb[DW-1] ? ub - (1 << DW) : ub;
        if (vop == 1'b0) begin
            ru     = ua + ub + int'(vcin);
            rs     = sa + sb + int'(vcin);
            r.cout = (ru >= (1 << DW));
        end else begin
            ru     = ua - ub - int'(vcin);
            rs     = sa - sb - int'(vcin);
            r.cout = (ru >= 0);
        end
        r.q    = DW'(ru);
        r.ovf  = (rs > (1 << (DW - 1)) - 1) || (rs < -(1 << (DW - 1)));
        r.zero = (r.q == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation to the instances in mask, scramble the inputs after
    // the accept edge, and record each instance's latency to out_valid.
    task automatic do_op(input logic [NI-1:0] mask, input logic [DW-1:0] va,
                         input logic [DW-1:0] vb, input logic vop, input logic vcin);
        int  cyc;
        bit  all;
        a = va; b = vb; op = vop; cin = vcin;
        in_valid = mask;
        for (int g = 0; g < NI; g++) begin
            lat[g] = -1;
            if (mask[g]) check($sformatf("in_ready_cw%0d", cw_of(g)), 32'(in_ready[g]), 32'd1);
        end
        tick();
        in_valid = '0;
        a   = DW'($urandom);
        b   = DW'($urandom);
        op  = 1'($urandom);
        cin = 1'($urandom);
        cyc = 0;
        all = 1'b0;
        while (cyc < 40 && !all) begin
            tick();
            cyc++;
            all = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (mask[g] && lat[g] < 0 && out_valid[g]) lat[g] = cyc;
                if (mask[g] && lat[g] < 0) all = 1'b0;
            end
        end
    endtask

    task automatic check_res(input logic [NI-1:0] mask, input res_t exp, input string tag);
        for (int g = 0; g < NI; g++) begin
            if (mask[g]) begin
                check($sformatf("%s_res_cw%0d", tag, cw_of(g)),
                      32'({q[g], cout[g], ovf[g], zero[g]}), 32'(exp));
                check($sformatf("%s_lat_cw%0d", tag, cw_of(g)), 32'(lat[g]), 32'(nch_of(g)));
            end
        end
    endtask

    task automatic pop(input logic [NI-1:0] mask);
        out_ready = mask;
        tick();
        out_ready = '0;
        for (int g = 0; g < NI; g++) begin
            if (mask[g]) check($sformatf("pop_cw%0d", cw_of(g)),
                               32'({out_valid[g], in_ready[g]}), 32'b01);
        end
    endtask

    vec_t tbl[8];
    res_t exp_r;
    int   acc[$];
    bit   seen;

    initial begin
        tbl[0] = '{14'h1234, 14'h0DCB, 1'b0, 1'b0, '{14'h1FFF, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{14'h3FFF, 14'h0001, 1'b0, 1'b0, '{14'h0000, 1'b1, 1'b0, 1'b1}};
        tbl[2] = '{14'h1FFF, 14'h0000, 1'b0, 1'b1, '{14'h2000, 1'b0, 1'b1, 1'b0}};
        tbl[3] = '{14'h0005, 14'h0007, 1'b1, 1'b0, '{14'h3FFE, 1'b0, 1'b0, 1'b0}};
        tbl[4] = '{14'h2000, 14'h0001, 1'b1, 1'b0, '{14'h1FFF, 1'b1, 1'b1, 1'b0}};
        tbl[5] = '{14'h0010, 14'h0010, 1'b1, 1'b1, '{14'h3FFF, 1'b0, 1'b0, 1'b0}};
        tbl[6] = '{14'h1234, 14'h1234, 1'b1, 1'b0, '{14'h0000, 1'b1, 1'b0, 1'b1}};
        tbl[7] = '{14'h2000, 14'h2000, 1'b0, 1'b0, '{14'h0000, 1'b1, 1'b1, 1'b1}};

        rst = 1'b1; in_valid = '0; out_ready = '0;
        a = '0; b = '0; op = 1'b0; cin = 1'b0;
        #1;
        for (int g = 0; g < NI; g++)
            check($sformatf("reset_cw%0d", cw_of(g)),
                  32'({q[g], cout[g], ovf[g], zero[g], out_valid[g], in_ready[g]}), 32'b01);
        tick(); tick();
        #2 rst = 1'b0;
        tick();

        // Directed vectors on every chunk width.
        for (int i = 0; i < 8; i++) begin
            do_op('1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].cin);
            check_res('1, tbl[i].exp, $sformatf("vec%0d", i));
            pop('1);
        end

        // Backpressure: result held, in_valid pulse ignored while DONE.
        do_op(4'b0001, 14'h1234, 14'h0DCB, 1'b0, 1'b0);
        exp_r = tbl[0].exp;
        check_res(4'b0001, exp_r, "bp_first");
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 32'({out_valid[0], in_ready[0], q[0], cout[0], ovf[0], zero[0]}),
                  32'({2'b10, exp_r}));
            in_valid = (i == 4) ? 4'b0001 : 4'b0000;
            a = 14'h0001; b = 14'h0001;
            tick();
        end
        in_valid = '0;
        pop(4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0]) seen = 1'b1;
        end
        check("bp_no_ghost", 32'({seen, in_ready[0], q[0]}), 32'({2'b01, exp_r.q}));

        // Issue interval with in_valid and out_ready held high.
        a = 14'h1234; b = 14'h0DCB; op = 1'b0; cin = 1'b0;
        in_valid = 4'b0001; out_ready = 4'b0001;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (in_ready[0]) acc.push_back(cyc);
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        check("interval_count", 32'(acc.size()), 32'd2);
        if (acc.size() == 2) check("interval_gap", 32'(acc[1] - acc[0]), 32'(nch_of(0) + 2));
        for (int i = 0; i < 20 && !in_ready[0]; i++) tick();
        out_ready = '0;
        check("interval_drain", 32'({in_ready[0], q[0]}), 32'({1'b1, 14'h1FFF}));

        // Asynchronous reset while chunk 2 is in progress.
        a = 14'h0F0F; b = 14'h0101; op = 1'b0; cin = 1'b0;
        in_valid = 4'b0001;
        tick();
        in_valid = '0;
        tick(); tick();
        #3 rst = 1'b1;
        #1;
        check("async_rst", 32'({q[0], cout[0], ovf[0], zero[0], out_valid[0], in_ready[0]}),
              32'b01);
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid[0]) seen = 1'b1;
        end
        check("rst_no_valid", 32'(seen), 32'd0);
        do_op(4'b0001, 14'h0001, 14'h0001, 1'b0, 1'b0);
        check_res(4'b0001, model(14'h0001, 14'h0001, 1'b0, 1'b0), "post_rst");
        check("post_rst_q", 32'(q[0]), 32'h0002);
        pop(4'b0001);

        // Random sweep across all chunk widths against the model.
        for (int i = 0; i < 1000; i++) begin
            logic [DW-1:0] va, vb;
            logic          vop, vcin;
            va   = DW'($urandom);
            vb   = DW'($urandom);
            vop  = 1'($urandom);
            vcin = 1'($urandom);
            if (i % 16 == 0) va = 14'h3FFF;
            if (i % 16 == 1) vb = 14'h2000;
            do_op('1, va, vb, vop, vcin);
            check_res('1, model(va, vb, vop, vcin), "rand");
            pop('1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
